// File: rtl/span_pixel_emitter.sv
// Serialises per-span coverage masks into a one-pixel-per-cycle coordinate stream.
// Optional per-tile pixel counters are enabled with the SPAN_PIX_COUNT_EN macro.
module span_pixel_emitter #(
    parameter int unsigned MASK_W  = 32,
    parameter int unsigned COORD_W = 11
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               span_valid,
    output logic               span_ready,
    input  logic [MASK_W-1:0]  span_mask,
    input  logic [COORD_W-1:0] span_x,
    input  logic [COORD_W-1:0] span_y,
    input  logic               span_last,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               pix_first,
    output logic               pix_last,
    output logic               tile_done,
    output logic               busy
`ifdef SPAN_PIX_COUNT_EN
    ,
    output logic [15:0]        tile_pix_count,
    output logic [15:0]        tile_pix_total
`endif
);

    localparam int unsigned IDX_W = $clog2(MASK_W);
    localparam int unsigned HI_W  = COORD_W - IDX_W;

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t              state_q, state_d;
    logic [MASK_W-1:0]   mask_q, mask_d;
    logic [HI_W-1:0]     base_q, base_d;
    logic                slast_q, slast_d;
    logic                valid_d;
    logic [COORD_W-1:0]  x_d, y_d;
    logic                first_d, last_d;
    logic                done_d;

    logic                hs;
    logic                accept;
    logic                load;
    logic                empty_done;
    logic [IDX_W-1:0]    span_idx, rem_idx;
    logic [MASK_W-1:0]   span_rest, rem_rest;
    logic [HI_W-1:0]     span_hi;
    logic                unused_low;

    // Index of the lowest set bit; result is don't-care for an all-zero mask.
    function automatic logic [IDX_W-1:0] lsb_idx(input logic [MASK_W-1:0] m);
        lsb_idx = '0;
        for (int i = int'(MASK_W) - 1; i >= 0; i--) begin
            if (m[i]) lsb_idx = IDX_W'(i);
        end
    endfunction

    assign span_idx   = lsb_idx(span_mask);
    assign span_rest  = span_mask & (span_mask - MASK_W'(1));
    assign rem_idx    = lsb_idx(mask_q);
    assign rem_rest   = mask_q & (mask_q - MASK_W'(1));
    assign span_hi    = span_x[COORD_W-1:IDX_W];
    assign unused_low = ^span_x[IDX_W-1:0];

    assign hs         = pix_valid && pix_ready;
    assign span_ready = reset_n && ((state_q == IDLE) ||
                                    (state_q == EMIT && hs && pix_last));
    assign accept     = span_valid && span_ready;
    assign load       = accept && (span_mask != '0);
    assign empty_done = accept && (span_mask == '0) && span_last;
    assign busy       = (state_q == EMIT);

`ifdef SPAN_PIX_COUNT_EN
    logic [15:0] cnt_d, total_d;
`endif

    // Next-state and output computation.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        base_d  = base_q;
        slast_d = slast_q;
        valid_d = pix_valid;
        x_d     = pix_x;
        y_d     = pix_y;
        first_d = pix_first;
        last_d  = pix_last;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
            end
            EMIT: begin
                if (hs) begin
                    if (!pix_last) begin
                        x_d     = {base_q, rem_idx};
                        mask_d  = rem_rest;
                        first_d = 1'b0;
                        last_d  = (rem_rest == '0);
                    end else begin
                        if (slast_q) done_d = 1'b1;
                        state_d = IDLE;
                        valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase

        if (empty_done) done_d = 1'b1;

        // A non-empty span takes over from either IDLE or the final handshake.
        if (load) begin
            state_d = EMIT;
            valid_d = 1'b1;
            base_d  = span_hi;
            slast_d = span_last;
            mask_d  = span_rest;
            x_d     = {span_hi, span_idx};
            y_d     = span_y;
            first_d = 1'b1;
            last_d  = (span_rest == '0);
        end
    end

`ifdef SPAN_PIX_COUNT_EN
    // Handshake counter clears on the tile_done cycle but keeps that cycle's pixel.
    always_comb begin
        cnt_d   = tile_pix_count;
        total_d = tile_pix_total;
        if (tile_done) begin
            cnt_d = hs ? 16'd1 : 16'd0;
        end else if (hs && tile_pix_count != 16'hFFFF) begin
            cnt_d = tile_pix_count + 16'd1;
        end
        if (done_d) total_d = cnt_d;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tile_pix_count <= '0;
            tile_pix_total <= '0;
        end else begin
            tile_pix_count <= cnt_d;
            tile_pix_total <= total_d;
        end
    end
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            mask_q    <= '0;
            base_q    <= '0;
            slast_q   <= 1'b0;
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_first <= 1'b0;
            pix_last  <= 1'b0;
            tile_done <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            base_q    <= base_d;
            slast_q   <= slast_d;
            pix_valid <= valid_d;
            pix_x     <= x_d;
            pix_y     <= y_d;
            pix_first <= first_d;
            pix_last  <= last_d;
            tile_done <= done_d;
        end
    end

endmodule

// File: tb/tb_span_pixel_emitter.sv
// Scoreboard bench for span_pixel_emitter: driver pushes expected pixels, negedge monitor checks.
// Counter ports are exercised when SPAN_PIX_COUNT_EN is defined.
module tb_span_pixel_emitter;

    localparam int unsigned MASK_W  = 32;
    localparam int unsigned COORD_W = 11;

    logic               clock = 1'b0;
    logic               reset_n = 1'b0;
    logic               span_valid = 1'b0;
    logic               span_ready;
    logic [MASK_W-1:0]  span_mask = '0;
    logic [COORD_W-1:0] span_x = '0;
    logic [COORD_W-1:0] span_y = '0;
    logic               span_last = 1'b0;
    logic               pix_valid;
    logic               pix_ready = 1'b1;
    logic [COORD_W-1:0] pix_x, pix_y;
    logic               pix_first, pix_last, tile_done, busy;
`ifdef SPAN_PIX_COUNT_EN
    logic [15:0]        tile_pix_count, tile_pix_total;
`endif

    span_pixel_emitter #(.MASK_W(MASK_W), .COORD_W(COORD_W)) dut (
        .clock(clock), .reset_n(reset_n),
        .span_valid(span_valid), .span_ready(span_ready), .span_mask(span_mask),
        .span_x(span_x), .span_y(span_y), .span_last(span_last),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
        .pix_first(pix_first), .pix_last(pix_last), .tile_done(tile_done), .busy(busy)
`ifdef SPAN_PIX_COUNT_EN
        , .tile_pix_count(tile_pix_count), .tile_pix_total(tile_pix_total)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               first;
        logic               last;
        logic               tend;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   pops = 0;
    int   pix_since = 0;
    int   exp_total = 0;
    int   ready_mode = 0;
    logic done_exp = 1'b0;
    logic first_exp = 1'b0;
    logic more_exp = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: every set bit in ascending order, coordinate = aligned base + bit position.
    task automatic model_push(input logic [31:0] mask, input logic [COORD_W-1:0] x,
                              input logic [COORD_W-1:0] y, input logic last);
        int   base;
        int   hi;
        logic first;
        exp_t e;
        base  = (int'(x) / int'(MASK_W)) * int'(MASK_W);
        hi    = -1;
        first = 1'b1;
        for (int i = 0; i < int'(MASK_W); i++) if (mask[i]) hi = i;
        for (int i = 0; i < int'(MASK_W); i++) begin
            if (mask[i]) begin
                e.x     = COORD_W'(base + i);
                e.y     = y;
                e.first = first;
                e.last  = (i == hi);
                e.tend  = (i == hi) && last;
                sb.push_back(e);
                first = 1'b0;
            end
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_span(input logic [31:0] mask, input logic [COORD_W-1:0] x,
                             input logic [COORD_W-1:0] y, input logic last);
        logic acc;
        span_valid = 1'b1;
        span_mask  = mask;
        span_x     = x;
        span_y     = y;
        span_last  = last;
        acc = 1'b0;
        for (int k = 0; k < 500 && !acc; k++) begin
            @(negedge clock);
            if (span_ready) acc = 1'b1;
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL span_accept timed out at %0t", $time);
        end else begin
            model_push(mask, x, y, last);
        end
        @(posedge clock);
        #1;
        span_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 3000 && (sb.size() != 0 || pix_valid); k++) @(negedge clock);
        check("drain_queue_empty", 32'(sb.size()), 32'd0);
        @(posedge clock);
        #1;
    endtask

    always @(posedge clock) begin
        #1;
        case (ready_mode)
            0:       pix_ready = 1'b1;
            1:       pix_ready = !pix_ready;
            default: pix_ready = ($urandom % 4) != 0;
        endcase
    end

    // Monitor: compares the presented pixel with the scoreboard head on every valid cycle.
    always @(negedge clock) begin
        logic new_done;
        exp_t e;
        if (!reset_n) begin
            done_exp  = 1'b0;
            first_exp = 1'b0;
            more_exp  = 1'b0;
            pix_since = 0;
        end else begin
            check("tile_done", 32'(tile_done), 32'(done_exp));
`ifdef SPAN_PIX_COUNT_EN
            if (done_exp) check("tile_pix_total", 32'(tile_pix_total), 32'(exp_total));
`endif
            if (first_exp) begin
                check("first_pixel_latency", 32'(pix_valid), 32'd1);
                check("first_pixel_flag", 32'(pix_first), 32'd1);
            end
            if (more_exp) check("no_bubble", 32'(pix_valid), 32'd1);
            new_done  = 1'b0;
            first_exp = 1'b0;
            more_exp  = 1'b0;
            if (pix_valid) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pixel x=%0h y=%0h with empty scoreboard", pix_x, pix_y);
                end else begin
                    e = sb[0];
                    check("pix_x", 32'(pix_x), 32'(e.x));
                    check("pix_y", 32'(pix_y), 32'(e.y));
                    check("pix_first", 32'(pix_first), 32'(e.first));
                    check("pix_last", 32'(pix_last), 32'(e.last));
                    if (pix_ready) begin
                        void'(sb.pop_front());
                        pops++;
                        pix_since++;
                        if (e.tend) new_done = 1'b1;
                        if (!e.last) more_exp = 1'b1;
                    end
                end
            end
            if (span_valid && span_ready) begin
                if (span_mask != '0) first_exp = 1'b1;
                else if (span_last) new_done = 1'b1;
            end
            if (new_done) begin
                exp_total = (pix_since > 65535) ? 65535 : pix_since;
                pix_since = 0;
            end
            done_exp = new_done;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        logic [31:0] m;
        #3;
        check("reset_pix_valid", 32'(pix_valid), 32'd0);
        check("reset_span_ready", 32'(span_ready), 32'd0);
        check("reset_tile_done", 32'(tile_done), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_pix_x", 32'(pix_x), 32'd0);
`ifdef SPAN_PIX_COUNT_EN
        check("reset_tile_pix_count", 32'(tile_pix_count), 32'd0);
`endif
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check("idle_span_ready", 32'(span_ready), 32'd1);

        send_span(32'h0000_0001, 11'd64, 11'd10, 1'b0);
        drain();
        send_span(32'hFFFF_FFFF, 11'h7E3, 11'd33, 1'b0);
        drain();
        ready_mode = 1;
        send_span(32'h8000_0012, 11'h2A5, 11'd400, 1'b0);
        drain();
        ready_mode = 0;
        @(posedge clock);
        #1;

        send_span(32'h0000_0003, 11'h120, 11'd5, 1'b0);
        send_span(32'h0000_0004, 11'h120, 11'd5, 1'b1);
        drain();
        repeat (2) @(posedge clock);
        #1;

        send_span(32'h0000_0000, 11'h300, 11'd9, 1'b1);
        @(negedge clock);
        check("empty_span_ready", 32'(span_ready), 32'd1);
        check("empty_no_pixel", 32'(pix_valid), 32'd0);
        @(posedge clock);
        #1;

        p0 = pops;
        send_span(32'h00FF_0000, 11'h100, 11'd20, 1'b1);
        for (int k = 0; k < 100 && pops < p0 + 3; k++) @(negedge clock);
        check("reset_wait_three_pixels", 32'(pops - p0), 32'd3);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        sb.delete();
        #1;
        check("abort_pix_valid", 32'(pix_valid), 32'd0);
        check("abort_span_ready", 32'(span_ready), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_tile_done", 32'(tile_done), 32'd0);
        check("abort_pix_x", 32'(pix_x), 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        send_span(32'h0000_0101, 11'h040, 11'd7, 1'b0);
        drain();

        ready_mode = 2;
        for (int n = 0; n < 40; n++) begin
            case ($urandom % 8)
                0:       m = 32'h0;
                1:       m = 32'hFFFF_FFFF;
                2:       m = 32'h1 << ($urandom % 32);
                default: m = $urandom & $urandom;
            endcase
            send_span(m, 11'($urandom_range(0, 2047)), 11'($urandom_range(0, 2047)),
                      ($urandom % 3) == 0);
            if (($urandom % 4) == 0) begin
                repeat ($urandom_range(1, 4)) @(posedge clock);
                #1;
            end
        end
        drain();
        ready_mode = 0;
        repeat (3) @(posedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/span_pixel_emitter.md
Name: span_pixel_emitter

Overview:
- Consumes per-span coverage masks from the triangle-visibility stage: a 32-bit mask per 32-pixel tile row, one bit per pixel, bit set = pixel inside the triangle.
- Serialises the set bits into a stream of individual pixel coordinates, one per cycle, for the downstream interpolator/shader.
- Sits between the inTri mask generator and the per-pixel attribute pipeline, with valid/ready handshakes on both sides.
- Empty spans are absorbed with zero output cycles. End-of-tile is signalled downstream.

Parameters:
- MASK_W, 32: pixels per span. Must be a power of 2. IDX_W = log2(MASK_W) is derived internally.
- COORD_W, 11: screen coordinate width for X and Y.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- span_valid  in  1  span input valid.
- span_ready  out  1  emitter can accept a span this cycle.
- span_mask  in  MASK_W  coverage; bit i = pixel at X base + i.
- span_x  in  COORD_W  span X. Bits [IDX_W-1:0] are ignored; base = span_x with the low IDX_W bits cleared.
- span_y  in  COORD_W  span Y.
- span_last  in  1  this span is the final span of the current tile.
- pix_valid  out  1  pixel output valid.
- pix_ready  in  1  downstream accepts the pixel.
- pix_x  out  COORD_W  pixel X = base + bit index.
- pix_y  out  COORD_W  pixel Y (span_y as latched).
- pix_first  out  1  first pixel of its span.
- pix_last  out  1  last set bit of its span.
- tile_done  out  1  single-cycle pulse marking tile completion.
- busy  out  1  state == EMIT.

Behaviour:
- Reset (asynchronous assert, synchronous deassert by the system):
  - Outputs: pix_valid=0, tile_done=0, busy=0, span_ready=0 while reset_n=0.
  - Registers: pix_x, pix_y, pix_first, pix_last = 0; remaining-mask register = 0; state = IDLE.
- span_ready is combinational:
  - 1 in IDLE.
  - 1 in EMIT when pix_valid && pix_ready && pix_last (back-to-back refill).
  - 0 otherwise.
- Span accept occurs when span_valid && span_ready. At accept:
  - If span_mask != 0: latch base, span_y, span_last, and the mask with its lowest set bit cleared.
  - Drive pix_x = base + index of the lowest set bit, pix_first=1, pix_last = (the cleared mask == 0).
  - Set pix_valid=1 the next cycle and enter EMIT.
  - Latency: first pixel is valid exactly 1 cycle after accept.
  - If span_mask == 0: nothing is latched for output. Go to (or remain in) IDLE, or drop pix_valid if coming from EMIT. If span_last=1, tile_done pulses the next cycle.
- EMIT, on pix_valid && pix_ready && !pix_last:
  - Next pixel = lowest set bit of the remaining mask. Clear that bit.
  - pix_first=0. pix_last = (remaining mask after clearing == 0).
  - Throughput is 1 pixel/cycle with no bubbles.
- EMIT, on handshake of the pixel with pix_last=1:
  - If the span was flagged last, tile_done=1 the next cycle. This applies even if a new span is accepted in the same cycle.
  - If a new span is accepted in the same cycle, its first pixel follows with no gap.
  - Otherwise go to IDLE and set pix_valid=0.
- Hold rule: while pix_valid && !pix_ready, pix_x, pix_y, pix_first, pix_last and the internal mask are frozen.
- Ordering:
  - Pixels are emitted in strictly ascending bit index.
  - A single-bit span gives pix_first=pix_last=1.
  - A full mask (all ones) gives MASK_W consecutive pixels.
- Arithmetic: pix_x = {span_x[COORD_W-1:IDX_W], idx}. This is concatenation, not an add, so there is no carry or overflow. No wrap beyond COORD_W.
- Priority encoder: lowest set bit, combinational, single cycle for MASK_W=32.
- Mid-span reset: the remaining mask is discarded. No tile_done is issued for the aborted tile.

Optional Feature:
- Macro: SPAN_PIX_COUNT_EN.
- When defined, two extra output ports exist:
  - tile_pix_count (16 bits): count of pixel handshakes since the last tile_done.
  - tile_pix_total (16 bits): the count captured at the cycle tile_done asserts, including a final pixel accepted on the completing handshake.
- tile_pix_count clears to 0 on the tile_done cycle. It counts a handshake occurring in that same cycle as 1.
- Both counters saturate at 16'hFFFF and reset to 0.
- When not defined, the ports and logic are absent. All other behaviour is identical.

Test Plan:
- mask=32'h0000_0001, x=64, y=10, span_last=0, pix_ready=1 -> one pixel x=64, y=10, first=1, last=1, valid 1 cycle after accept; tile_done stays 0.
- mask=32'hFFFF_FFFF, x=0x7E3 (base 0x7E0), pix_ready=1 -> 32 consecutive pixels x=0x7E0..0x7FF, no bubble; first on x=0x7E0, last on x=0x7FF.
- mask=32'h8000_0012, pix_ready toggling 1/0 each cycle -> x=base+1, base+4, base+31 in order. Outputs are stable during each ready=0 cycle. Last is asserted on base+31.
- Back-to-back spans A=32'h0000_0003, B=32'h0000_0004 (span_last=1), pix_ready=1 -> pixels base+0, base+1, then B's base+2 the very next cycle. tile_done pulses 1 cycle after B's handshake.
- Empty span mask=0, span_last=1 while IDLE -> span_ready stays 1, no pix_valid, tile_done pulses the following cycle. With SPAN_PIX_COUNT_EN, tile_pix_total=0.
- reset_n low mid-emission of 32'h00FF_0000 after 3 pixels -> pix_valid=0 immediately. After release, a new span emits correctly and no tile_done appears.
